// File: rtl/load_writeback_unit.sv
// Multi-cycle load engine: issues a word-aligned memory read, extracts and extends
// the addressed byte/half/word, then writes it to the register file for one cycle.
module load_writeback_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [2:0]                req_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic                      rf_write_enable,
  output logic [3:0]                rf_write_width,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_reg_addr,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      busy,
  output logic                      load_error
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] W_BYTE = 4'd1;
  localparam logic [3:0] W_HALF = 4'd2;
  localparam logic [3:0] W_WORD = 4'd4;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_WB, ST_ERR} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  off_q, off_d;
  logic [2:0]                  f3_q, f3_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;

  logic                        req_ready_d, mem_req_valid_d, busy_d, load_error_d;
  logic                        rf_write_enable_d;
  logic [ADDR_WIDTH-1:0]       mem_req_addr_d;
  logic [3:0]                  rf_write_width_d;
  logic [REG_ADDR_WIDTH-1:0]   rf_write_reg_addr_d;
  logic [DATA_WIDTH-1:0]       rf_write_data_d;

  logic                        legal_c;
  logic [7:0]                  byte_c;
  logic [15:0]                 half_c;
  logic [DATA_WIDTH-1:0]       ext_c;
  logic [3:0]                  width_c;

  // Request legality: known funct3 and natural alignment
  always_comb begin
    legal_c = 1'b0;
    case (req_funct3)
      F3_LB, F3_LBU: legal_c = 1'b1;
      F3_LH, F3_LHU: legal_c = ~req_addr[0];
      F3_LW:         legal_c = (req_addr[1:0] == 2'b00);
      default:       legal_c = 1'b0;
    endcase
  end

  // Little-endian lane select and extension of the response word
  always_comb begin
    byte_c  = mem_rsp_data[{off_q, 3'b000} +: 8];
    half_c  = mem_rsp_data[{off_q[1], 4'b0000} +: 16];
    ext_c   = mem_rsp_data;
    width_c = W_WORD;
    case (f3_q)
      F3_LB:  ext_c = {{(DATA_WIDTH-8){byte_c[7]}}, byte_c};
      F3_LH:  ext_c = {{(DATA_WIDTH-16){half_c[15]}}, half_c};
      F3_LBU: begin
        ext_c   = {{(DATA_WIDTH-8){1'b0}}, byte_c};
        width_c = W_BYTE;
      end
      F3_LHU: begin
        ext_c   = {{(DATA_WIDTH-16){1'b0}}, half_c};
        width_c = W_HALF;
      end
      default: begin
        ext_c   = mem_rsp_data;
        width_c = W_WORD;
      end
    endcase
  end

  // Next state; registered outputs follow the state being entered
  always_comb begin
    state_d             = state_q;
    off_d               = off_q;
    f3_d                = f3_q;
    rd_d                = rd_q;
    mem_req_addr_d      = mem_req_addr;
    rf_write_width_d    = rf_write_width;
    rf_write_reg_addr_d = rf_write_reg_addr;
    rf_write_data_d     = rf_write_data;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          off_d = req_addr[1:0];
          f3_d  = req_funct3;
          rd_d  = req_rd;
          if (legal_c) begin
            state_d        = ST_REQ;
            mem_req_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_valid && mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d             = ST_WB;
          rf_write_width_d    = width_c;
          rf_write_reg_addr_d = rd_q;
          rf_write_data_d     = ext_c;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d       = (state_d == ST_IDLE);
    busy_d            = (state_d != ST_IDLE);
    mem_req_valid_d   = (state_d == ST_REQ);
    load_error_d      = (state_d == ST_ERR);
    rf_write_enable_d = (state_d == ST_WB) && (rd_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      off_q             <= '0;
      f3_q              <= '0;
      rd_q              <= '0;
      req_ready         <= 1'b1;
      busy              <= 1'b0;
      mem_req_valid     <= 1'b0;
      mem_req_addr      <= '0;
      load_error        <= 1'b0;
      rf_write_enable   <= 1'b0;
      rf_write_width    <= '0;
      rf_write_reg_addr <= '0;
      rf_write_data     <= '0;
    end else begin
      state_q           <= state_d;
      off_q             <= off_d;
      f3_q              <= f3_d;
      rd_q              <= rd_d;
      req_ready         <= req_ready_d;
      busy              <= busy_d;
      mem_req_valid     <= mem_req_valid_d;
      mem_req_addr      <= mem_req_addr_d;
      load_error        <= load_error_d;
      rf_write_enable   <= rf_write_enable_d;
      rf_write_width    <= rf_write_width_d;
      rf_write_reg_addr <= rf_write_reg_addr_d;
      rf_write_data     <= rf_write_data_d;
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Bench for load_writeback_unit: per-cycle comparison against a transaction-level
// model driven by directed and randomized load sequences.
module tb_load_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_write_enable;
  logic [3:0]  rf_write_width;
  logic [4:0]  rf_write_reg_addr;
  logic [31:0] rf_write_data;
  logic        busy;
  logic        load_error;

  load_writeback_unit dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_funct3        (req_funct3),
    .req_rd            (req_rd),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .rf_write_enable   (rf_write_enable),
    .rf_write_width    (rf_write_width),
    .rf_write_reg_addr (rf_write_reg_addr),
    .rf_write_data     (rf_write_data),
    .busy              (busy),
    .load_error        (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int err_count = 0;
  logic [31:0] cap_data  = '0;
  logic [3:0]  cap_width = '0;
  logic [4:0]  cap_reg   = '0;

  // Expected outputs for the current cycle, plus the held register-file payload
  bit          chk_en = 1'b0;
  bit          exp_rr, exp_busy, exp_mv, exp_we, exp_err;
  logic [31:0] exp_maddr = '0;
  logic [3:0]  m_width = '0;
  logic [4:0]  m_reg   = '0;
  logic [31:0] m_data  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_width(input logic [2:0] f3);
    case (f3)
      3'd4:    return 4'd1;
      3'd5:    return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'h10000   : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Single compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    if (rf_write_enable) begin
      wr_count++;
      cap_data  = rf_write_data;
      cap_width = rf_write_width;
      cap_reg   = rf_write_reg_addr;
    end
    if (load_error) err_count++;
    if (chk_en) begin
      chk("req_ready",         32'(req_ready),         32'(exp_rr));
      chk("busy",              32'(busy),              32'(exp_busy));
      chk("mem_req_valid",     32'(mem_req_valid),     32'(exp_mv));
      chk("rf_write_enable",   32'(rf_write_enable),   32'(exp_we));
      chk("load_error",        32'(load_error),        32'(exp_err));
      chk("rf_write_width",    32'(rf_write_width),    32'(m_width));
      chk("rf_write_reg_addr", 32'(rf_write_reg_addr), 32'(m_reg));
      chk("rf_write_data",     rf_write_data,          m_data);
      if (exp_mv) chk("mem_req_addr", mem_req_addr, exp_maddr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit rr, input bit bsy, input bit mv, input bit we, input bit er);
    exp_rr = rr; exp_busy = bsy; exp_mv = mv; exp_we = we; exp_err = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      req_valid     = 1'b0;
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_data  = $urandom;
      set_exp(1, 0, 0, 0, 0);
    end
  endtask

  // One load transaction; the WB (or ERR) cycle is the last cycle this task owns
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] w, input int rdy_wait, input int rsp_wait,
                         input bit spur);
    cyc();
    req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_rd = rd;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    set_exp(1, 0, 0, 0, 0);
    cyc();
    req_addr = $urandom; req_funct3 = 3'($urandom); req_rd = 5'($urandom);
    req_valid = 1'($urandom_range(0, 1));
    if (!ref_legal(f3, a)) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = 1'($urandom_range(0, 1));
      set_exp(0, 1, 0, 0, 1);
      return;
    end
    exp_maddr = a & 32'hFFFF_FFFC;
    for (int i = 0; i <= rdy_wait; i++) begin
      if (i > 0) begin
        cyc();
        req_valid = 1'($urandom_range(0, 1));
      end
      mem_req_ready = (i == rdy_wait);
      mem_rsp_valid = spur && ((i == rdy_wait) || ($urandom_range(0, 1) == 1));
      mem_rsp_data  = $urandom;
      set_exp(0, 1, 1, 0, 0);
    end
    for (int j = 0; j <= rsp_wait; j++) begin
      cyc();
      req_valid     = 1'($urandom_range(0, 1));
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = (j == rsp_wait);
      mem_rsp_data  = (j == rsp_wait) ? w : $urandom;
      set_exp(0, 1, 0, 0, 0);
    end
    cyc();
    req_valid = 1'($urandom_range(0, 1));
    mem_rsp_valid = 1'($urandom_range(0, 1));
    mem_rsp_data  = $urandom;
    m_width = ref_width(f3);
    m_reg   = rd;
    m_data  = ref_data(f3, a, w);
    set_exp(0, 1, 0, rd != 5'd0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, e0;
    logic [2:0]  f3;
    logic [31:0] a;
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    set_exp(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Word load, minimum latency
    do_load(32'h100, 3'd2, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    idle(1);
    chk("t1_data", cap_data, 32'hDEADBEEF);
    chk("t1_width", 32'(cap_width), 32'd4);
    chk("t1_rd", 32'(cap_reg), 32'd5);

    // Byte loads, signed and unsigned
    do_load(32'h203, 3'd0, 5'd3, 32'h80112233, 0, 0, 0);
    idle(1);
    chk("t2_lb_data", cap_data, 32'hFFFFFF80);
    chk("t2_lb_width", 32'(cap_width), 32'd4);
    do_load(32'h203, 3'd4, 5'd3, 32'h80112233, 0, 0, 0);
    idle(1);
    chk("t2_lbu_data", cap_data, 32'h00000080);
    chk("t2_lbu_width", 32'(cap_width), 32'd1);

    // Half loads, back-to-back
    do_load(32'h2, 3'd1, 5'd8, 32'h80017FFF, 0, 0, 0);
    do_load(32'h0, 3'd5, 5'd9, 32'h80017FFF, 0, 0, 0);
    idle(1);
    chk("t3_lhu_data", cap_data, 32'h00007FFF);
    chk("t3_lhu_width", 32'(cap_width), 32'd2);

    // Misaligned loads rejected
    w0 = wr_count; e0 = err_count;
    do_load(32'h102, 3'd2, 5'd4, 32'h0, 0, 0, 0);
    do_load(32'h101, 3'd1, 5'd4, 32'h0, 0, 0, 0);
    idle(1);
    chk("t4_errors", 32'(err_count - e0), 32'd2);
    chk("t4_writes", 32'(wr_count - w0), 32'd0);

    // Stalled handshake, delayed response, spurious early response
    w0 = wr_count;
    do_load(32'h404, 3'd2, 5'd11, 32'h13572468, 3, 4, 1);
    idle(1);
    chk("t5_writes", 32'(wr_count - w0), 32'd1);
    chk("t5_data", cap_data, 32'h13572468);

    // Load to x0 never strobes the write
    w0 = wr_count;
    do_load(32'h500, 3'd2, 5'd0, 32'hCAFEF00D, 0, 1, 0);
    idle(1);
    chk("t6_rd0_writes", 32'(wr_count - w0), 32'd0);

    // Reset while waiting for the response
    w0 = wr_count;
    cyc();
    req_valid = 1'b1; req_addr = 32'h300; req_funct3 = 3'd2; req_rd = 5'd7;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    set_exp(1, 0, 0, 0, 0);
    cyc();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    exp_maddr = 32'h300;
    set_exp(0, 1, 1, 0, 0);
    cyc();
    mem_req_ready = 1'b0;
    set_exp(0, 1, 0, 0, 0);
    #2;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_rf_data", rf_write_data, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
    cyc();
    reset = 1'b1;
    m_width = '0; m_reg = '0; m_data = '0;
    set_exp(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle(3);
    chk("t6_rst_writes", 32'(wr_count - w0), 32'd0);

    // Randomized loads
    for (int k = 0; k < 300; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ((f3[1:0] == 2'd2) ? 32'hFFFF_FFFC :
                                             (f3[1:0] == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      do_load(a, f3, 5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
Multi-cycle load engine between the MEM-stage control and the register file write port. It accepts one load request at a time and issues a word-aligned read to data memory over a valid/ready handshake. It waits for the response, extracts and extends the addressed byte, half or word, and then drives the register file write port for exactly one cycle. Misaligned and illegal loads are rejected with an error pulse and no register write.

Parameters:
ADDR_WIDTH, 32, byte address width of req_addr and mem_req_addr.
REG_ADDR_WIDTH, 5, destination register index width; matches the register file.
DATA_WIDTH, 32, memory word and register width; fixed at 32, other values unsupported.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 resets).
req_valid  input  1  load request present.
req_ready  output  1  unit can accept a request (high only in IDLE).
req_addr  input  ADDR_WIDTH  byte address of the load.
req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
req_rd  input  REG_ADDR_WIDTH  destination register.
mem_req_valid  output  1  memory read request.
mem_req_ready  input  1  memory accepts the request.
mem_req_addr  output  ADDR_WIDTH  word-aligned address {req_addr[ADDR_WIDTH-1:2],2'b00}.
mem_rsp_valid  input  1  read data valid.
mem_rsp_data  input  DATA_WIDTH  little-endian read word.
rf_write_enable  output  1  register file write strobe.
rf_write_width  output  4  1=byte, 2=half, 4=word; matches the register file write-width codes.
rf_write_reg_addr  output  REG_ADDR_WIDTH  destination register.
rf_write_data  output  DATA_WIDTH  extended load data.
busy  output  1  state != IDLE.
load_error  output  1  one-cycle pulse on a misaligned or illegal funct3 request.

Behaviour:
- All outputs are registered. Reset value of every output is 0, except req_ready=1. State resets to IDLE.
- States: IDLE, REQ, WAIT, WB, ERR.
- IDLE:
  - On req_valid&&req_ready, latch addr, funct3 and rd.
  - Illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 -> ERR.
  - Otherwise -> REQ.
- ERR: load_error=1 for exactly one cycle; no memory request, no register write; -> IDLE.
- REQ:
  - mem_req_valid=1, with mem_req_addr held stable until mem_req_ready.
  - On mem_req_valid&&mem_req_ready -> WAIT; mem_req_valid drops the following cycle.
- WAIT:
  - On mem_rsp_valid, latch the extracted result -> WB.
  - mem_rsp_valid in any other state is ignored.
  - A response in the same cycle as the request handshake is not accepted.
- WB:
  - rf_write_enable=1 for exactly one cycle with width, rd and data stable; -> IDLE.
  - If rd==0, rf_write_enable stays 0; the rest of the sequence is unchanged.
- Extraction, little-endian:
  - byte = mem_rsp_data[8*addr[1:0] +: 8].
  - half = mem_rsp_data[16*addr[1] +: 16].
- Extension and width:
  - LB/LH: sign-extend to 32 bits; rf_write_width=4.
  - LBU: zero-extend the byte; rf_write_width=1.
  - LHU: zero-extend the half; rf_write_width=2.
  - LW: word as-is; rf_write_width=4.
  - Upper bits of rf_write_data are always zero for LBU/LHU.
- Minimum latency: accept at cycle T, mem_req_valid at T+1 (ready=1), response sampled at T+2, rf_write_enable at T+3. req_ready is high again at T+4.
- Back-to-back: a new request can be accepted in the cycle after WB. Requests are never accepted while busy.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs cleared. No write occurs, and a late memory response is ignored.
- Between WB pulses, rf_write_* hold their last values; only rf_write_enable gates the write.

Test Plan:
1. LW addr 0x100, memory returns 0xDEADBEEF, ready=1 -> mem_req_addr=0x100; at T+3 write_enable=1, width=4, data=0xDEADBEEF, rd as given.
2. LB addr 0x203, data 0x80112233 -> data=0xFFFFFF80, width=4. LBU at the same address -> data=0x00000080, width=1.
3. LH addr 0x2, data 0x8001_7FFF -> data=0xFFFF8001. LHU addr 0x0, same data -> data=0x00007FFF, width=2.
4. LW addr 0x102 and LH addr 0x101 -> load_error pulses 1 cycle each; mem_req_valid and rf_write_enable never assert; req_ready=1 two cycles after accept.
5. mem_req_ready held 0 for 3 cycles, then rsp delayed 4 cycles, with a spurious rsp during REQ -> mem_req_addr stable; exactly one write with the delayed data; req_ready=0 throughout.
6. LW to rd=0 -> no rf_write_enable. Separately, reset asserted (0) while in WAIT, then a response arrives -> no write, state IDLE, req_ready=1.
